// File: rtl/mss_fabric_ahb_slave.sv
`default_nettype none
// ============================================================================
// Module   : mss_fabric_ahb_slave
// Brief    : AHB-Lite memory slave for the MSS fabric master port.
//            Configurable depth, base address and wait states, with byte and
//            halfword lanes, two-cycle ERROR responses and same-word write
//            forwarding for back-to-back read-after-write.
//            Optional doorbell interrupt on word DEPTH-1, enabled by the
//            macro MSS_FABRIC_AHB_SLAVE_DOORBELL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mss_fabric_ahb_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h4005_0000,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0
) (
    input  logic        SYSCLK,
    input  logic        NSYSRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        IRQ
);

    localparam int          c_idxw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_span = 32'(DEPTH * 4);
    localparam logic [3:0]  c_ws   = 4'(WAIT_STATES);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_err1 = 3'd3;
    localparam logic [2:0] c_st_err2 = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [3:0]        r_wcnt;
    logic [c_idxw-1:0] r_idx;
    logic              r_write;
    logic [3:0]        r_mask;
    logic [31:0]       r_hrdata;
    logic [31:0]       r_mem [DEPTH];

    logic [31:0]       w_offset;
    logic [c_idxw-1:0] w_acc_idx;
    logic              w_hreadyout;
    logic              w_accept;
    logic              w_err;
    logic [3:0]        w_mask;
    logic [31:0]       w_mask32;
    logic [31:0]       w_merged;
    logic [31:0]       w_fwd_word;
    logic              w_commit;
    logic              w_load_acc;
    logic              w_load_wait;
    logic              w_unused;

    // HTRANS[0] only distinguishes SEQ from NONSEQ, which this slave treats alike
    assign w_unused = HTRANS[0];

    // Address decode: offsets below the base wrap to huge values and fail the range check
    assign w_offset  = HADDR - BASE_ADDR;
    assign w_acc_idx = w_offset[c_idxw+1:2];

    // New transfers are taken only when this slave is not stalling its own data phase
    assign w_hreadyout = (r_state != c_st_wait) && (r_state != c_st_err1);
    assign w_accept    = HSEL && HREADY && HTRANS[1] && w_hreadyout;

    assign w_err = (w_offset >= c_span) ||
                   (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    // Little-endian byte lane selection from size and low address bits
    always_comb begin
        w_mask = 4'b0000;
        case (HSIZE)
            3'd0:    w_mask = 4'b0001 << HADDR[1:0];
            3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    assign w_mask32 = {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};
    assign w_merged = (r_mem[r_idx] & ~w_mask32) | (HWDATA & w_mask32);

    // A pending write lands at the edge that ends its (always ready) DATA phase
    assign w_commit = NSYSRESET && (r_state == c_st_data) && r_write;

    // Zero-wait reads sample memory at the address edge, so forward a write landing on the same edge
    assign w_fwd_word  = (w_commit && (r_idx == w_acc_idx)) ? w_merged : r_mem[w_acc_idx];
    assign w_load_acc  = w_accept && !HWRITE && !w_err && (c_ws == 4'd0);
    assign w_load_wait = (r_state == c_st_wait) && (r_wcnt == 4'd0) && !r_write;

    // Transfer sequencing: wait-state countdown, two-cycle error, otherwise follow the bus
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_wait: begin
                if (r_wcnt == 4'd0) begin
                    w_state_nxt = c_st_data;
                end
            end
            c_st_err1: w_state_nxt = c_st_err2;
            default: begin
                if (!w_accept) begin
                    w_state_nxt = c_st_idle;
                end else if (w_err) begin
                    w_state_nxt = c_st_err1;
                end else if (c_ws != 4'd0) begin
                    w_state_nxt = c_st_wait;
                end else begin
                    w_state_nxt = c_st_data;
                end
            end
        endcase
    end

    // State and captured address-phase information
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            r_state <= c_st_idle;
            r_wcnt  <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx   <= w_acc_idx;
                r_write <= HWRITE && !w_err;
                r_mask  <= w_mask;
                r_wcnt  <= c_ws - 4'd1;
            end else if ((r_state == c_st_wait) && (r_wcnt != 4'd0)) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    // Storage array; deliberately not reset
    always_ff @(posedge SYSCLK) begin
        if (w_commit) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    // Read data register; holds the last read word between reads
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            r_hrdata <= 32'h0;
        end else if (w_load_acc) begin
            r_hrdata <= w_fwd_word;
        end else if (w_load_wait) begin
            r_hrdata <= r_mem[r_idx];
        end
    end

    assign HREADYOUT = w_hreadyout;
    assign HRESP     = (r_state == c_st_err1) || (r_state == c_st_err2);
    assign HRDATA    = r_hrdata;

`ifdef MSS_FABRIC_AHB_SLAVE_DOORBELL_EN
    localparam logic [c_idxw-1:0] c_last = c_idxw'(DEPTH - 1);

    logic r_irq;

    // Doorbell: a write to the last word raises IRQ, a completed read of it clears IRQ
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            r_irq <= 1'b0;
        end else if (w_commit && (r_idx == c_last)) begin
            r_irq <= 1'b1;
        end else if ((r_state == c_st_data) && !r_write && (r_idx == c_last)) begin
            r_irq <= 1'b0;
        end
    end

    assign IRQ = r_irq;
`else
    assign IRQ = 1'b0;
`endif

endmodule
`default_nettype wire
